pe_injection_port: RTL and testbench
====================================

# pe_injection_port

Router-side terminator of the PE injection link: accepts phits driven by the processing element's producer (data, send request, new-packet flag, VC number), buffers them in per-VC FIFOs, and back-pressures the PE through a per-VC ready. Buffered packets are forwarded wormhole-style to the router's local input over a valid/ready phit interface, one VC at a time under round-robin arbitration. It sits between each PE and the local port of its cluster router.

## Interface
- phit_size, 16, phit width in bits (must be ≥16)
- flit_size, 1, phits per flit
- addr_length, 8, destination address width
- addr_place_in_header, 0, LSB position of destination address in the header phit
- no_vc, 8, number of virtual channels
- floorplusone_log2_no_vc, 4, VC index width
- buf_depth, 4, phits per VC FIFO (power of two, ≥2)

Ports:
- clk  in  1  clock; all state updates on posedge
- full_reset  in  1  synchronous, active-high reset
- in_data  in  phit_size  phit from PE
- in_sent_req  in  1  phit valid from PE
- in_new  in  1  phit is first of a packet (header)
- in_vc_no  in  floorplusone_log2_no_vc  VC targeted by current phit
- out_ready  out  1  selected VC can accept a phit (to PE's in_ready)
- out_data  out  phit_size  phit to router
- out_sent_req  out  1  phit valid to router
- out_new  out  1  header phit
- out_tail  out  1  last phit of packet
- out_vc_no  out  floorplusone_log2_no_vc  VC of forwarded phit
- in_ready  in  1  router accepts phit
- out_dest_addr  out  addr_length  destination of packet in flight (valid while out_sent_req)
- protocol_error  out  1  sticky framing error
- no_packet_inject_report  out  32  packets forwarded (stats build only)
- stall_cycles_report  out  32  cycles PE was back-pressured (stats build only)

## Operation
- Packet format: phit 0 has in_new=1, dest at [addr_place_in_header +: addr_length]; phit 1 bits [15:0] = packet length L in flits including header. Phits per packet P = max(L*flit_size, 2).
- out_ready = ~full[in_vc_no] (combinational from registered FIFO state and in_vc_no); independent of in_sent_req.
- Write: in_sent_req & out_ready at posedge pushes phit plus in_new tag into FIFO[in_vc_no].
- Per-VC input framing: state IDLE/BODY. IDLE + in_new=1 -> BODY; BODY + in_new=1, or IDLE + in_new=0 -> phit dropped, protocol_error set (sticky until reset).
- Output FSM: ARB -> SEND -> ARB. ARB: round-robin from last granted VC+1 over VCs whose FIFO head is tagged new; winner registered, move to SEND. SEND: head phit of granted VC presented; out_sent_req = FIFO nonempty. Handshake out_sent_req & in_ready pops. Phit counter captures L on phit 1, asserts out_tail on phit P-1; tail pop returns to ARB.
- Lock: granted VC holds output until tail, even if its FIFO drains (out_sent_req low meanwhile).
- Arithmetic: phit counter 17 bits; L=0 or 1 treated as P=2.

## Timing
- Reset values: out_sent_req=0, out_new=0, out_tail=0, out_data=0, out_vc_no=0, out_dest_addr=0, protocol_error=0, reports=0, out_ready=1 (all FIFOs empty), RR pointer=no_vc-1, all VCs IDLE.
- Latency: header accepted at edge N -> ARB at N+1 -> out_sent_req at N+2 minimum; body phits stream one per cycle when both sides ready.
- Full: out_ready drops the cycle after the write that fills; a pop in the same cycle frees space visible next cycle (no same-cycle pass-through).
- Simultaneous push and pop on the same VC: both occur, count unchanged.
- Reset mid-packet: FIFOs flushed, FSMs to IDLE/ARB, partial packets discarded.

## Configuration
- INJ_PORT_STATS_EN defined: no_packet_inject_report increments on each tail handshake; stall_cycles_report increments each cycle in_sent_req & ~out_ready; both wrap at 2^32.
- Undefined: counters not built; both report outputs tied to 0.

## Structure
- Shared package noc_pkg: phit type, VC index type, LENGTH_PHIT_INDEX=1, LENGTH_FIELD_WIDTH=16, output FSM state enum.
- Sub-module inj_vc_fifo (one per VC, generate loop): buf_depth × (phit_size+1) storage, push/pop, full/empty, head output.

## Test plan
- Single packet, VC 2, L=4, flit_size=1 -> 4 phits out on VC 2, out_new on first, out_tail on fourth, out_dest_addr = header addr, first out_sent_req 2 cycles after header write.
- in_ready held 0, PE streams 6 phits to VC 0, buf_depth=4 -> out_ready low after 4th write, stall_cycles_report counts (stats build), no phit lost after in_ready=1.
- Headers to VC 1 and VC 5 same cycle window -> packets forwarded whole, VC 1 then VC 5, no interleaving; next arbitration starts at VC 6.
- Body phit to IDLE VC 3 -> dropped, protocol_error=1 and stays 1; later valid packet on VC 3 forwarded normally.
- full_reset asserted mid-packet -> next cycle out_sent_req=0, out_ready=1, protocol_error=0, fresh packet forwarded correctly.
- L=0 header -> forwarded as 2 phits, out_tail on phit 1.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC types and helpers for the PE injection port.
// Holds phit/VC types, length-field constants and the output FSM states.
package noc_pkg;

    localparam int PHIT_SIZE          = 16;
    localparam int VC_IDX_W           = 4;
    localparam int LENGTH_PHIT_INDEX  = 1;
    localparam int LENGTH_FIELD_WIDTH = 16;
    localparam int CNT_W              = 17;

    typedef logic [PHIT_SIZE-1:0] phit_t;
    typedef logic [VC_IDX_W-1:0]  vc_idx_t;

    typedef enum logic {
        ARB  = 1'b0,
        SEND = 1'b1
    } out_state_t;

    // Phits in a packet whose length field reads len flits; a header-only
    // or zero length still carries the length phit, so never below 2.
    function automatic logic [CNT_W-1:0] pkt_phits(
        input logic [LENGTH_FIELD_WIDTH-1:0] len,
        input int                            fs
    );
        logic [CNT_W-1:0] p;
        p = CNT_W'(int'(len) * fs);
        if (p < CNT_W'(2)) p = CNT_W'(2);
        return p;
    endfunction

endpackage

// File: rtl/inj_vc_fifo.sv
// Per-VC phit FIFO: DEPTH entries of W bits, registered full/empty.
// Ports: clk, rst (sync high), push/din, pop, dout (head), full, empty.
module inj_vc_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/pe_injection_port.sv
// Router-side end of the PE injection link: per-VC FIFOs with input framing
// checks, round-robin wormhole forwarding of whole packets to the router.
// Ports: clk, full_reset (sync high); PE side in_data/in_sent_req/in_new/
// in_vc_no -> out_ready; router side out_data/out_sent_req/out_new/out_tail/
// out_vc_no/out_dest_addr <- in_ready; protocol_error (sticky); reports.
// Build option: INJ_PORT_STATS_EN enables packet and stall counters.
module pe_injection_port
    import noc_pkg::*;
#(
    parameter int phit_size               = PHIT_SIZE,
    parameter int flit_size               = 1,
    parameter int addr_length             = 8,
    parameter int addr_place_in_header    = 0,
    parameter int no_vc                   = 8,
    parameter int floorplusone_log2_no_vc = VC_IDX_W,
    parameter int buf_depth               = 4
) (
    input  logic                               clk,
    input  logic                               full_reset,
    input  logic [phit_size-1:0]               in_data,
    input  logic                               in_sent_req,
    input  logic                               in_new,
    input  logic [floorplusone_log2_no_vc-1:0] in_vc_no,
    output logic                               out_ready,
    output logic [phit_size-1:0]               out_data,
    output logic                               out_sent_req,
    output logic                               out_new,
    output logic                               out_tail,
    output logic [floorplusone_log2_no_vc-1:0] out_vc_no,
    input  logic                               in_ready,
    output logic [addr_length-1:0]             out_dest_addr,
    output logic                               protocol_error,
    output logic [31:0]                        no_packet_inject_report,
    output logic [31:0]                        stall_cycles_report
);

    localparam int VW = floorplusone_log2_no_vc;
    localparam int EW = phit_size + 1;

    logic [no_vc-1:0] full, empty, push, pop, bad, req;
    logic [EW-1:0]    head [no_vc];
    logic             sel_full, wr;
    logic [EW-1:0]    g_head;
    logic             g_empty;

    out_state_t             state, state_nxt;
    logic [VW-1:0]          grant, grant_nxt, winner;
    logic [CNT_W-1:0]       ocnt, ocnt_nxt, oplen, oplen_nxt, plen_cur;
    logic [addr_length-1:0] dest, dest_nxt;
    logic [EW-1:0]          win_head;
    logic                   found, hs, is_len_phit, tail_raw;

    // Out-of-range VC numbers read as full, so they are never written.
    always_comb begin
        sel_full = 1'b1;
        g_head   = '0;
        g_empty  = 1'b1;
        for (int v = 0; v < no_vc; v++) begin
            if (in_vc_no == VW'(v)) sel_full = full[v];
            if (grant == VW'(v)) begin
                g_head  = head[v];
                g_empty = empty[v];
            end
        end
    end

    assign out_ready = ~sel_full;
    assign wr        = in_sent_req & out_ready;

    for (genvar v = 0; v < no_vc; v++) begin : g_vc
        logic             body, hit, ok, last;
        logic [CNT_W-1:0] idx, plen, plen_now;

        assign hit      = wr & (in_vc_no == VW'(v));
        // Header only when idle, body only inside a packet.
        assign ok       = in_new ^ body;
        assign plen_now = (idx == CNT_W'(LENGTH_PHIT_INDEX))
                        ? pkt_phits(in_data[LENGTH_FIELD_WIDTH-1:0],
                                    flit_size)
                        : plen;
        assign last     = (idx == plen_now - CNT_W'(1));
        assign push[v]  = hit & ok;
        assign bad[v]   = hit & ~ok;
        assign req[v]   = ~empty[v] & head[v][phit_size];

        always_ff @(posedge clk) begin
            if (full_reset) begin
                body <= 1'b0;
                idx  <= '0;
                plen <= '0;
            end else if (push[v]) begin
                if (in_new) begin
                    body <= 1'b1;
                    idx  <= CNT_W'(1);
                end else begin
                    if (idx == CNT_W'(LENGTH_PHIT_INDEX)) plen <= plen_now;
                    if (last) body <= 1'b0;
                    else      idx  <= idx + CNT_W'(1);
                end
            end
        end

        inj_vc_fifo #(
            .W     (EW),
            .DEPTH (buf_depth)
        ) u_fifo (
            .clk   (clk),
            .rst   (full_reset),
            .push  (push[v]),
            .din   ({in_new, in_data}),
            .pop   (pop[v]),
            .dout  (head[v]),
            .full  (full[v]),
            .empty (empty[v])
        );
    end

    // Round robin: VCs above the last grant first, then wrap around.
    always_comb begin
        found    = 1'b0;
        winner   = grant;
        win_head = '0;
        for (int v = 0; v < no_vc; v++) begin
            if (!found && req[v] && (VW'(v) > grant)) begin
                found    = 1'b1;
                winner   = VW'(v);
                win_head = head[v];
            end
        end
        for (int v = 0; v < no_vc; v++) begin
            if (!found && req[v] && (VW'(v) <= grant)) begin
                found    = 1'b1;
                winner   = VW'(v);
                win_head = head[v];
            end
        end
    end

    assign is_len_phit = (ocnt == CNT_W'(LENGTH_PHIT_INDEX));
    assign plen_cur    = is_len_phit
                       ? pkt_phits(g_head[LENGTH_FIELD_WIDTH-1:0], flit_size)
                       : oplen;
    assign tail_raw    = (ocnt != '0) && (ocnt == plen_cur - CNT_W'(1));

    assign out_sent_req  = (state == SEND) & ~g_empty;
    assign hs            = out_sent_req & in_ready;
    assign out_data      = out_sent_req ? g_head[phit_size-1:0] : '0;
    assign out_new       = out_sent_req & g_head[phit_size];
    assign out_tail      = out_sent_req & tail_raw;
    assign out_vc_no     = (state == SEND) ? grant : '0;
    assign out_dest_addr = dest;

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        ocnt_nxt  = ocnt;
        oplen_nxt = oplen;
        dest_nxt  = dest;
        pop       = '0;
        unique case (state)
            ARB: begin
                if (found) begin
                    state_nxt = SEND;
                    grant_nxt = winner;
                    ocnt_nxt  = '0;
                    dest_nxt  = win_head[addr_place_in_header +: addr_length];
                end
            end
            SEND: begin
                if (hs) begin
                    for (int v = 0; v < no_vc; v++)
                        pop[v] = (grant == VW'(v));
                    ocnt_nxt = ocnt + CNT_W'(1);
                    if (is_len_phit) oplen_nxt = plen_cur;
                    if (tail_raw)    state_nxt = ARB;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (full_reset) begin
            state          <= ARB;
            grant          <= VW'(no_vc - 1);
            ocnt           <= '0;
            oplen          <= '0;
            dest           <= '0;
            protocol_error <= 1'b0;
        end else begin
            state          <= state_nxt;
            grant          <= grant_nxt;
            ocnt           <= ocnt_nxt;
            oplen          <= oplen_nxt;
            dest           <= dest_nxt;
            protocol_error <= protocol_error | (|bad);
        end
    end

`ifdef INJ_PORT_STATS_EN
    logic [31:0] pkt_cnt, stall_cnt;

    always_ff @(posedge clk) begin
        if (full_reset) begin
            pkt_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (hs & tail_raw)             pkt_cnt   <= pkt_cnt + 32'd1;
            if (in_sent_req & ~out_ready) stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign no_packet_inject_report = pkt_cnt;
    assign stall_cycles_report     = stall_cnt;
`else
    assign no_packet_inject_report = '0;
    assign stall_cycles_report     = '0;
`endif

endmodule

// File: tb/tb_pe_injection_port.sv
// Directed bench for pe_injection_port with hand-computed expectations.
// Covers reset, single packet, full FIFO, round robin, framing, L=0, reset.
module tb_pe_injection_port;

    logic        clk = 1'b0;
    logic        full_reset;
    logic [15:0] in_data;
    logic        in_sent_req;
    logic        in_new;
    logic [3:0]  in_vc_no;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_sent_req;
    logic        out_new;
    logic        out_tail;
    logic [3:0]  out_vc_no;
    logic        in_ready;
    logic [7:0]  out_dest_addr;
    logic        protocol_error;
    logic [31:0] no_packet_inject_report;
    logic [31:0] stall_cycles_report;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pe_injection_port dut (
        .clk                     (clk),
        .full_reset              (full_reset),
        .in_data                 (in_data),
        .in_sent_req             (in_sent_req),
        .in_new                  (in_new),
        .in_vc_no                (in_vc_no),
        .out_ready               (out_ready),
        .out_data                (out_data),
        .out_sent_req            (out_sent_req),
        .out_new                 (out_new),
        .out_tail                (out_tail),
        .out_vc_no               (out_vc_no),
        .in_ready                (in_ready),
        .out_dest_addr           (out_dest_addr),
        .protocol_error          (protocol_error),
        .no_packet_inject_report (no_packet_inject_report),
        .stall_cycles_report     (stall_cycles_report)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called and returns at a negedge; one write attempt at the next posedge.
    task automatic push(input logic [15:0] d, input logic nw,
                        input logic [3:0] vc);
        in_data     = d;
        in_new      = nw;
        in_vc_no    = vc;
        in_sent_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_sent_req = 1'b0;
    endtask

    // Waits (bounded) for a valid phit, checks it, lets it handshake.
    task automatic expect_out(input string tag, input logic [15:0] d,
                              input logic nw, input logic tl,
                              input logic [3:0] vc, input logic [7:0] dst);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (out_sent_req) seen = 1'b1;
            else @(negedge clk);
        end
        chk({tag, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({tag, "_data"}, 32'(out_data), 32'(d));
            chk({tag, "_new"}, 32'(out_new), 32'(nw));
            chk({tag, "_tail"}, 32'(out_tail), 32'(tl));
            chk({tag, "_vc"}, 32'(out_vc_no), 32'(vc));
            chk({tag, "_dest"}, 32'(out_dest_addr), 32'(dst));
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic chk_stats(input string tag, input logic [31:0] pkts,
                             input logic [31:0] stalls);
`ifdef INJ_PORT_STATS_EN
        chk({tag, "_pkts"}, no_packet_inject_report, pkts);
        chk({tag, "_stalls"}, stall_cycles_report, stalls);
`else
        chk({tag, "_pkts"}, no_packet_inject_report, 32'd0 & pkts);
        chk({tag, "_stalls"}, stall_cycles_report, 32'd0 & stalls);
`endif
    endtask

    initial begin
        full_reset  = 1'b1;
        in_data     = '0;
        in_sent_req = 1'b0;
        in_new      = 1'b0;
        in_vc_no    = 4'd0;
        in_ready    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        full_reset = 1'b0;

        chk("rst_sent_req", 32'(out_sent_req), 32'd0);
        chk("rst_new", 32'(out_new), 32'd0);
        chk("rst_tail", 32'(out_tail), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_vc", 32'(out_vc_no), 32'd0);
        chk("rst_dest", 32'(out_dest_addr), 32'd0);
        chk("rst_perr", 32'(protocol_error), 32'd0);
        chk("rst_ready", 32'(out_ready), 32'd1);
        chk_stats("rst", 32'd0, 32'd0);

        // Single packet on VC 2, L=4, latency of first valid.
        push(16'h00A5, 1'b1, 4'd2);
        chk("lat_edge1", 32'(out_sent_req), 32'd0);
        push(16'h0004, 1'b0, 4'd2);
        chk("lat_edge2", 32'(out_sent_req), 32'd1);
        push(16'h1111, 1'b0, 4'd2);
        push(16'h2222, 1'b0, 4'd2);
        in_ready = 1'b1;
        expect_out("p1_0", 16'h00A5, 1'b1, 1'b0, 4'd2, 8'hA5);
        expect_out("p1_1", 16'h0004, 1'b0, 1'b0, 4'd2, 8'hA5);
        expect_out("p1_2", 16'h1111, 1'b0, 1'b0, 4'd2, 8'hA5);
        expect_out("p1_3", 16'h2222, 1'b0, 1'b1, 4'd2, 8'hA5);
        in_ready = 1'b0;

        // Fill VC 0 with the router stalled, then drain a 6-phit packet.
        push(16'h0033, 1'b1, 4'd0);
        push(16'h0006, 1'b0, 4'd0);
        push(16'hB002, 1'b0, 4'd0);
        chk("fill_3_ready", 32'(out_ready), 32'd1);
        push(16'hB003, 1'b0, 4'd0);
        chk("fill_4_ready", 32'(out_ready), 32'd0);
        in_data     = 16'hB004;
        in_new      = 1'b0;
        in_sent_req = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        in_sent_req = 1'b0;
        chk("full_still", 32'(out_ready), 32'd0);
        chk_stats("stall", 32'd1, 32'd2);
        in_ready = 1'b1;
        expect_out("p2_0", 16'h0033, 1'b1, 1'b0, 4'd0, 8'h33);
        in_ready = 1'b0;
        chk("full_freed", 32'(out_ready), 32'd1);
        push(16'hB004, 1'b0, 4'd0);
        in_ready = 1'b1;
        expect_out("p2_1", 16'h0006, 1'b0, 1'b0, 4'd0, 8'h33);
        in_ready = 1'b0;
        push(16'hB005, 1'b0, 4'd0);
        in_ready = 1'b1;
        expect_out("p2_2", 16'hB002, 1'b0, 1'b0, 4'd0, 8'h33);
        expect_out("p2_3", 16'hB003, 1'b0, 1'b0, 4'd0, 8'h33);
        expect_out("p2_4", 16'hB004, 1'b0, 1'b0, 4'd0, 8'h33);
        expect_out("p2_5", 16'hB005, 1'b0, 1'b1, 4'd0, 8'h33);
        in_ready = 1'b0;

        // Round robin: VC1, then VC5, then VC6 ahead of VC0.
        push(16'h0011, 1'b1, 4'd1);
        push(16'h0055, 1'b1, 4'd5);
        push(16'h0003, 1'b0, 4'd1);
        push(16'hC102, 1'b0, 4'd1);
        push(16'h0002, 1'b0, 4'd5);
        push(16'h0010, 1'b1, 4'd0);
        push(16'h0001, 1'b0, 4'd0);
        push(16'h0066, 1'b1, 4'd6);
        push(16'h0002, 1'b0, 4'd6);
        in_ready = 1'b1;
        expect_out("rr1_0", 16'h0011, 1'b1, 1'b0, 4'd1, 8'h11);
        expect_out("rr1_1", 16'h0003, 1'b0, 1'b0, 4'd1, 8'h11);
        expect_out("rr1_2", 16'hC102, 1'b0, 1'b1, 4'd1, 8'h11);
        expect_out("rr5_0", 16'h0055, 1'b1, 1'b0, 4'd5, 8'h55);
        expect_out("rr5_1", 16'h0002, 1'b0, 1'b1, 4'd5, 8'h55);
        expect_out("rr6_0", 16'h0066, 1'b1, 1'b0, 4'd6, 8'h66);
        expect_out("rr6_1", 16'h0002, 1'b0, 1'b1, 4'd6, 8'h66);
        expect_out("rr0_0", 16'h0010, 1'b1, 1'b0, 4'd0, 8'h10);
        expect_out("rr0_1", 16'h0001, 1'b0, 1'b1, 4'd0, 8'h10);
        in_ready = 1'b0;
        chk("no_err_yet", 32'(protocol_error), 32'd0);

        // Body phit to an idle VC is dropped and flagged.
        push(16'h1234, 1'b0, 4'd3);
        chk("perr_set", 32'(protocol_error), 32'd1);
        @(negedge clk);
        chk("drop_no_send", 32'(out_sent_req), 32'd0);
        push(16'h0077, 1'b1, 4'd3);
        push(16'h0002, 1'b0, 4'd3);
        in_ready = 1'b1;
        expect_out("v3_0", 16'h0077, 1'b1, 1'b0, 4'd3, 8'h77);
        expect_out("v3_1", 16'h0002, 1'b0, 1'b1, 4'd3, 8'h77);
        in_ready = 1'b0;
        chk("perr_sticky", 32'(protocol_error), 32'd1);

        // L=0 header: two phits, tail on the length phit.
        push(16'h0088, 1'b1, 4'd7);
        push(16'h0000, 1'b0, 4'd7);
        in_ready = 1'b1;
        expect_out("l0_0", 16'h0088, 1'b1, 1'b0, 4'd7, 8'h88);
        expect_out("l0_1", 16'h0000, 1'b0, 1'b1, 4'd7, 8'h88);
        in_ready = 1'b0;
        chk_stats("pre_rst", 32'd8, 32'd2);

        // Reset mid-packet, then a fresh packet on the same VC.
        push(16'h0099, 1'b1, 4'd2);
        push(16'h0005, 1'b0, 4'd2);
        in_ready = 1'b1;
        expect_out("mid_0", 16'h0099, 1'b1, 1'b0, 4'd2, 8'h99);
        in_ready   = 1'b0;
        full_reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        full_reset = 1'b0;
        chk("mrst_sent_req", 32'(out_sent_req), 32'd0);
        chk("mrst_ready", 32'(out_ready), 32'd1);
        chk("mrst_perr", 32'(protocol_error), 32'd0);
        chk_stats("mrst", 32'd0, 32'd0);
        push(16'h00AB, 1'b1, 4'd2);
        push(16'h0002, 1'b0, 4'd2);
        in_ready = 1'b1;
        expect_out("fr_0", 16'h00AB, 1'b1, 1'b0, 4'd2, 8'hAB);
        expect_out("fr_1", 16'h0002, 1'b0, 1'b1, 4'd2, 8'hAB);
        in_ready = 1'b0;
        chk("fr_perr", 32'(protocol_error), 32'd0);
        chk_stats("fr", 32'd1, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
